// File: rtl/csi2_packet_scheduler.sv
// CSI-2 packet scheduler: turns frame/line event pulses into registered short/long
// packet controls, tracks frame/line/byte counts and delays the byte stream.
module csi2_packet_scheduler #(
  parameter int DATA_DELAY          = 3,
  parameter bit FRAME_NUMBER_ENABLE = 1'b1,
  parameter int FRAME_NUMBER_MAX    = 65535
) (
  input  logic        clock_camera_byte,
  input  logic        reset_camera_byte_n,
  input  logic [15:0] image_x_size_in,
  input  logic [1:0]  data_mode_in,
  input  logic [1:0]  virtual_channel_in,
  input  logic        fv_start_in,
  input  logic        fv_end_in,
  input  logic        lv_start_in,
  input  logic        lv_end_in,
  input  logic        byte_data_en_in,
  input  logic [7:0]  byte_data_in,
  input  logic        txfr_en_in,
  output logic        sp_en_out,
  output logic        lp_en_out,
  output logic [5:0]  dt_out,
  output logic [1:0]  vc_out,
  output logic [15:0] wc_out,
  output logic [7:0]  byte_data_out,
  output logic        byte_data_en_out,
  output logic        txfr_en_out,
  output logic [15:0] frame_number_out,
  output logic [15:0] line_count_out,
  output logic        config_error_out,
  output logic        protocol_error_out,
  output logic        length_error_out
);
  localparam logic [15:0] FN_MAX = 16'(FRAME_NUMBER_MAX);

  typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;
  state_t state, state_nxt;

  function automatic logic [19:0] long_wc(input logic [1:0] m, input logic [15:0] x);
    case (m)
      2'd0:    long_wc = {4'd0, x};
      2'd1:    long_wc = ({4'd0, x} * 20'd10) >> 3;
      2'd2:    long_wc = ({4'd0, x} * 20'd3) >> 1;
      default: long_wc = {3'd0, x, 1'b0};
    endcase
  endfunction

  function automatic logic [5:0] long_dt(input logic [1:0] m);
    case (m)
      2'd0:    long_dt = 6'h2A;
      2'd1:    long_dt = 6'h2B;
      2'd2:    long_dt = 6'h2C;
      default: long_dt = 6'h22;
    endcase
  endfunction

  // Long packet parameters are resolved once per frame from the latched config.
  logic [5:0]  dt_long_q;
  logic [15:0] wc_long_q, byte_cnt;
  logic [1:0]  vc_q;

  logic        ev_fs, ev_fe, ev_ls, ev_le, multi;
  logic [19:0] cfg_wc;
  logic        cfg_bad;
  logic [15:0] fn_inc, cnt_inc;

  logic        sp_nxt, lp_nxt, proto_nxt, cfg_nxt, len_nxt, latch;
  logic [5:0]  dt_nxt;
  logic [1:0]  vc_nxt;
  logic [15:0] wc_nxt, fn_nxt, line_nxt, cnt_nxt;

  // Only the highest-priority event of a cycle is considered; the rest are dropped.
  assign ev_fs = fv_start_in;
  assign ev_fe = fv_end_in & ~fv_start_in;
  assign ev_ls = lv_start_in & ~fv_start_in & ~fv_end_in;
  assign ev_le = lv_end_in & ~fv_start_in & ~fv_end_in & ~lv_start_in;
  assign multi = (fv_start_in & (fv_end_in | lv_start_in | lv_end_in)) |
                 (fv_end_in & (lv_start_in | lv_end_in)) | (lv_start_in & lv_end_in);

  assign cfg_wc  = long_wc(data_mode_in, image_x_size_in);
  assign cfg_bad = (data_mode_in == 2'd1 && image_x_size_in[1:0] != 2'b00) ||
                   (data_mode_in == 2'd2 && image_x_size_in[0]) ||
                   image_x_size_in == 16'd0 || cfg_wc > 20'h0FFFF;
  assign fn_inc  = (frame_number_out == 16'd0 || frame_number_out >= FN_MAX) ? 16'd1
                                                                             : frame_number_out + 16'd1;
  assign cnt_inc = (byte_data_en_in && byte_cnt != 16'hFFFF) ? byte_cnt + 16'd1 : byte_cnt;

  always_ff @(posedge clock_camera_byte or negedge reset_camera_byte_n)
    if (!reset_camera_byte_n) state <= IDLE;
    else                      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    sp_nxt    = 1'b0;
    lp_nxt    = 1'b0;
    proto_nxt = multi;
    cfg_nxt   = 1'b0;
    len_nxt   = 1'b0;
    latch     = 1'b0;
    dt_nxt    = dt_out;
    vc_nxt    = vc_out;
    wc_nxt    = wc_out;
    fn_nxt    = frame_number_out;
    line_nxt  = line_count_out;
    cnt_nxt   = (state == LINE) ? cnt_inc : byte_cnt;
    if (ev_fs) begin
      if (state == IDLE) begin
        state_nxt = FRAME;
        sp_nxt    = 1'b1;
        dt_nxt    = 6'h00;
        vc_nxt    = virtual_channel_in;
        wc_nxt    = FRAME_NUMBER_ENABLE ? fn_inc : 16'd0;
        fn_nxt    = fn_inc;
        line_nxt  = 16'd0;
        latch     = 1'b1;
        cfg_nxt   = cfg_bad;
      end else proto_nxt = 1'b1;
    end else if (ev_fe) begin
      if (state == IDLE) proto_nxt = 1'b1;
      else begin
        // FE inside a line aborts it: no length check, no line increment.
        if (state == LINE) proto_nxt = 1'b1;
        state_nxt = IDLE;
        sp_nxt    = 1'b1;
        dt_nxt    = 6'h01;
        vc_nxt    = vc_q;
        wc_nxt    = FRAME_NUMBER_ENABLE ? frame_number_out : 16'd0;
      end
    end else if (ev_ls) begin
      if (state == FRAME) begin
        state_nxt = LINE;
        lp_nxt    = 1'b1;
        dt_nxt    = dt_long_q;
        vc_nxt    = vc_q;
        wc_nxt    = wc_long_q;
        cnt_nxt   = 16'd0;
      end else proto_nxt = 1'b1;
    end else if (ev_le) begin
      if (state == LINE) begin
        state_nxt = FRAME;
        line_nxt  = (line_count_out == 16'hFFFF) ? line_count_out : line_count_out + 16'd1;
        len_nxt   = (cnt_inc != wc_long_q);
      end else proto_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock_camera_byte or negedge reset_camera_byte_n)
    if (!reset_camera_byte_n) begin
      sp_en_out          <= 1'b0;
      lp_en_out          <= 1'b0;
      dt_out             <= 6'h00;
      vc_out             <= 2'd0;
      wc_out             <= 16'd0;
      frame_number_out   <= 16'd0;
      line_count_out     <= 16'd0;
      config_error_out   <= 1'b0;
      protocol_error_out <= 1'b0;
      length_error_out   <= 1'b0;
      dt_long_q          <= 6'h2A;
      wc_long_q          <= 16'd0;
      vc_q               <= 2'd0;
      byte_cnt           <= 16'd0;
    end else begin
      sp_en_out          <= sp_nxt;
      lp_en_out          <= lp_nxt;
      dt_out             <= dt_nxt;
      vc_out             <= vc_nxt;
      wc_out             <= wc_nxt;
      frame_number_out   <= fn_nxt;
      line_count_out     <= line_nxt;
      config_error_out   <= cfg_nxt;
      protocol_error_out <= proto_nxt;
      length_error_out   <= len_nxt;
      byte_cnt           <= cnt_nxt;
      if (latch) begin
        dt_long_q <= long_dt(data_mode_in);
        wc_long_q <= cfg_wc[15:0];
        vc_q      <= virtual_channel_in;
      end
    end

  // Payload pipeline runs regardless of packet state.
  logic [DATA_DELAY:1][7:0] data_pipe;
  logic [DATA_DELAY:1]      vld_pipe;

  always_ff @(posedge clock_camera_byte or negedge reset_camera_byte_n)
    if (!reset_camera_byte_n) begin
      data_pipe   <= '0;
      vld_pipe    <= '0;
      txfr_en_out <= 1'b0;
    end else begin
      data_pipe[1] <= byte_data_in;
      vld_pipe[1]  <= byte_data_en_in;
      for (int i = 2; i <= DATA_DELAY; i++) begin
        data_pipe[i] <= data_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1];
      end
      txfr_en_out <= txfr_en_in;
    end

  assign byte_data_out    = data_pipe[DATA_DELAY];
  assign byte_data_en_out = vld_pipe[DATA_DELAY];
endmodule

// File: tb/tb_csi2_packet_scheduler.sv
// Directed bench: frame/line sequences, error pulses, frame-number wrap, data delay, reset.
module tb_csi2_packet_scheduler;
  localparam int DD = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] x;
  logic [1:0]  mode, vc_in;
  logic        fs, fe, ls, le, en, txfr;
  logic [7:0]  din;

  logic        sp, lp, den, txo, cfg, proto, len;
  logic [5:0]  dt;
  logic [1:0]  vc;
  logic [15:0] wc, fn, lc;
  logic [7:0]  dout;

  logic        n_sp, n_lp, n_den, n_txo, n_cfg, n_proto, n_len;
  logic [5:0]  n_dt;
  logic [1:0]  n_vc;
  logic [15:0] n_wc, n_fn, n_lc;
  logic [7:0]  n_dout;

  csi2_packet_scheduler #(.DATA_DELAY(DD), .FRAME_NUMBER_ENABLE(1'b1), .FRAME_NUMBER_MAX(3)) u_dut (
    .clock_camera_byte(clk), .reset_camera_byte_n(rst_n), .image_x_size_in(x),
    .data_mode_in(mode), .virtual_channel_in(vc_in), .fv_start_in(fs), .fv_end_in(fe),
    .lv_start_in(ls), .lv_end_in(le), .byte_data_en_in(en), .byte_data_in(din),
    .txfr_en_in(txfr), .sp_en_out(sp), .lp_en_out(lp), .dt_out(dt), .vc_out(vc), .wc_out(wc),
    .byte_data_out(dout), .byte_data_en_out(den), .txfr_en_out(txo), .frame_number_out(fn),
    .line_count_out(lc), .config_error_out(cfg), .protocol_error_out(proto),
    .length_error_out(len));

  csi2_packet_scheduler #(.DATA_DELAY(DD), .FRAME_NUMBER_ENABLE(1'b0), .FRAME_NUMBER_MAX(3)) u_nofn (
    .clock_camera_byte(clk), .reset_camera_byte_n(rst_n), .image_x_size_in(x),
    .data_mode_in(mode), .virtual_channel_in(vc_in), .fv_start_in(fs), .fv_end_in(fe),
    .lv_start_in(ls), .lv_end_in(le), .byte_data_en_in(en), .byte_data_in(din),
    .txfr_en_in(txfr), .sp_en_out(n_sp), .lp_en_out(n_lp), .dt_out(n_dt), .vc_out(n_vc),
    .wc_out(n_wc), .byte_data_out(n_dout), .byte_data_en_out(n_den), .txfr_en_out(n_txo),
    .frame_number_out(n_fn), .line_count_out(n_lc), .config_error_out(n_cfg),
    .protocol_error_out(n_proto), .length_error_out(n_len));

  int checks = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle event pulse; byte enable is held for that cycle only.
  task automatic pkt(input logic a, input logic b, input logic c, input logic d);
    fs = a; fe = b; ls = c; le = d;
    tick();
    fs = 1'b0; fe = 1'b0; ls = 1'b0; le = 1'b0; en = 1'b0;
  endtask

  task automatic bytes(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  ev;     // {fs, fe, ls, le}
    logic [1:0]  mode;
    logic [15:0] x;
    logic [1:0]  vci;
    logic [4:0]  flg;    // {sp, lp, proto, cfg, len}
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl[13];
  logic [8:0] hist[0:31];

  initial begin
    x = 16'd0; mode = 2'd0; vc_in = 2'd0;
    fs = 1'b0; fe = 1'b0; ls = 1'b0; le = 1'b0; en = 1'b0; din = 8'd0; txfr = 1'b0;

    // RGB565 frame 2 with mid-frame config change and protocol violations, then RAW10 frame 3.
    tbl[0]  = '{4'b1000, 2'd3, 16'd640,  2'd2, 5'b10000, 6'h00, 2'd2, 16'd2};
    tbl[1]  = '{4'b0000, 2'd0, 16'd100,  2'd1, 5'b00000, 6'h00, 2'd2, 16'd2};
    tbl[2]  = '{4'b0010, 2'd0, 16'd100,  2'd1, 5'b01000, 6'h22, 2'd2, 16'd1280};
    tbl[3]  = '{4'b0001, 2'd0, 16'd100,  2'd1, 5'b00001, 6'h22, 2'd2, 16'd1280};
    tbl[4]  = '{4'b1000, 2'd0, 16'd100,  2'd1, 5'b00100, 6'h22, 2'd2, 16'd1280};
    tbl[5]  = '{4'b1010, 2'd0, 16'd100,  2'd1, 5'b00100, 6'h22, 2'd2, 16'd1280};
    tbl[6]  = '{4'b0010, 2'd0, 16'd100,  2'd1, 5'b01000, 6'h22, 2'd2, 16'd1280};
    tbl[7]  = '{4'b0010, 2'd0, 16'd100,  2'd1, 5'b00100, 6'h22, 2'd2, 16'd1280};
    tbl[8]  = '{4'b0100, 2'd0, 16'd100,  2'd1, 5'b10100, 6'h01, 2'd2, 16'd2};
    tbl[9]  = '{4'b0010, 2'd0, 16'd100,  2'd1, 5'b00100, 6'h01, 2'd2, 16'd2};
    tbl[10] = '{4'b0100, 2'd0, 16'd100,  2'd1, 5'b00100, 6'h01, 2'd2, 16'd2};
    tbl[11] = '{4'b1010, 2'd1, 16'd1290, 2'd1, 5'b10110, 6'h00, 2'd1, 16'd3};
    tbl[12] = '{4'b0010, 2'd1, 16'd1290, 2'd1, 5'b01000, 6'h2B, 2'd1, 16'd1612};

    #12;
    chk("reset_sp", 32'(sp), 0);
    chk("reset_dt_wc", {10'd0, dt, wc}, 0);
    chk("reset_fn_lc", {fn, lc}, 0);
    chk("reset_err", {29'd0, cfg, proto, len}, 0);
    rst_n = 1'b1;
    tick();

    // RAW10 1288 px -> 1610 byte lines
    mode = 2'd1; x = 16'd1288; vc_in = 2'd0;
    pkt(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fs1_flags", {27'd0, sp, lp, proto, cfg, len}, 32'b10000);
    chk("fs1_dt_vc_wc", {8'd0, dt, vc, wc}, {8'd0, 6'h00, 2'd0, 16'd1});
    chk("fs1_nofn_wc", 32'(n_wc), 0);
    chk("fs1_fn", 32'(fn), 1);
    tick();
    chk("sp_pulse_end", 32'(sp), 0);
    pkt(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ls1", {25'd0, lp, dt}, {25'd0, 1'b1, 6'h2B});
    chk("ls1_wc", 32'(wc), 1610);
    bytes(1610);
    pkt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("le1_len", {30'd0, len, proto}, 0);
    chk("le1_lc", 32'(lc), 1);
    pkt(1'b0, 1'b0, 1'b1, 1'b0);
    bytes(1609);
    en = 1'b1;
    pkt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("le2_len_byte_on_lv_end", 32'(len), 0);
    chk("le2_lc", 32'(lc), 2);
    pkt(1'b0, 1'b1, 1'b0, 1'b0);
    chk("fe1", {8'd0, sp, proto, dt, wc}, {8'd0, 1'b1, 1'b0, 6'h01, 16'd1});
    chk("fe1_nofn_wc", 32'(n_wc), 0);

    for (int i = 0; i < 13; i++) begin
      mode = tbl[i].mode; x = tbl[i].x; vc_in = tbl[i].vci;
      pkt(tbl[i].ev[3], tbl[i].ev[2], tbl[i].ev[1], tbl[i].ev[0]);
      chk($sformatf("row%0d_flags", i), {27'd0, sp, lp, proto, cfg, len}, {27'd0, tbl[i].flg});
      chk($sformatf("row%0d_dt_vc_wc", i), {8'd0, dt, vc, wc}, {8'd0, tbl[i].dt, tbl[i].vc, tbl[i].wc});
      if (tbl[i].flg[4]) chk($sformatf("row%0d_nofn_wc", i), 32'(n_wc), 0);
    end

    // 1611 bytes against wc 1612 -> length error
    bytes(1611);
    pkt(1'b0, 1'b0, 1'b0, 1'b1);
    chk("len_err", 32'(len), 1);
    tick();
    chk("len_err_pulse_end", 32'(len), 0);
    chk("fr3_lc", 32'(lc), 1);
    pkt(1'b0, 1'b1, 1'b0, 1'b0);
    chk("fe3", {8'd0, sp, proto, dt, wc}, {8'd0, 1'b1, 1'b0, 6'h01, 16'd3});
    chk("fe3_fn", 32'(fn), 3);

    // FRAME_NUMBER_MAX = 3 -> wraps to 1
    mode = 2'd0; x = 16'd100; vc_in = 2'd0;
    pkt(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_fs", {fn, wc}, {16'd1, 16'd1});
    pkt(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_fe", {15'd0, sp, wc}, {15'd0, 1'b1, 16'd1});

    // Data delay: 0x01..0x10, txfr toggling
    for (int n = 0; n < 24; n++) begin
      din  = (n < 16) ? 8'(n + 1) : 8'h00;
      en   = (n < 16);
      txfr = n[0];
      hist[n] = {en, din};
      tick();
      chk($sformatf("txfr_%0d", n), 32'(txo), 32'(n[0]));
      if (n >= DD - 1)
        chk($sformatf("delay_%0d", n), {23'd0, den, dout}, {23'd0, hist[n - DD + 1]});
    end
    en = 1'b0; din = 8'd0; txfr = 1'b0;

    // RAW12 odd width -> config error; reset mid-line
    mode = 2'd2; x = 16'd1001; vc_in = 2'd3;
    pkt(1'b1, 1'b0, 1'b0, 1'b0);
    chk("raw12_fs", {13'd0, cfg, vc, fn}, {13'd0, 1'b1, 2'd3, 16'd2});
    pkt(1'b0, 1'b0, 1'b1, 1'b0);
    chk("raw12_ls", {8'd0, dt, vc, wc}, {8'd0, 6'h2C, 2'd3, 16'd1501});
    en = 1'b1; din = 8'hAA; txfr = 1'b1;
    repeat (DD + 1) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pkt", {7'd0, sp, lp, dt, vc, wc}, 0);
    chk("rst_data", {21'd0, dout, den, txo}, 0);
    chk("rst_cnt", {fn, lc}, 0);
    chk("rst_err", {29'd0, cfg, proto, len}, 0);
    en = 1'b0; din = 8'd0; txfr = 1'b0;
    rst_n = 1'b1;
    tick();

    // RGB565 40000 px overflows -> config error, truncated wc
    mode = 2'd3; x = 16'd40000; vc_in = 2'd0;
    pkt(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_fs", {15'd0, cfg, wc}, {15'd0, 1'b1, 16'd1});
    chk("post_rst_fn", 32'(fn), 1);
    pkt(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_ls", {10'd0, dt, wc}, {10'd0, 6'h22, 16'd14464});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/csi2_packet_scheduler.md
Name: csi2_packet_scheduler

Overview:
Byte-clock-domain scheduler between the pixel-to-byte converter and the CSI-2 transmitter. Converts frame/line start/end pulses into registered short/long packet controls (sp_en, lp_en, data type, virtual channel, word count) and delays byte data to align with the packet header. Generalises the fixed RAW10 glue with runtime data-type modes, virtual channel, frame numbering, a parametrised data delay and protocol/length checking.

Parameters:
DATA_DELAY, 3, byte data/enable pipeline depth in cycles (legal range 1..8)
FRAME_NUMBER_ENABLE, 1, 1 = FS/FE word count carries frame number; 0 = word count 0
FRAME_NUMBER_MAX, 65535, last frame number before wrap to 1 (legal range 1..65535)

Ports:
clock_camera_byte  in  1  byte clock
reset_camera_byte_n  in  1  asynchronous active-low reset
image_x_size_in  in  16  pixels per line, latched at fv_start
data_mode_in  in  2  0 RAW8, 1 RAW10, 2 RAW12, 3 RGB565; latched at fv_start
virtual_channel_in  in  2  VC; latched at fv_start
fv_start_in, fv_end_in, lv_start_in, lv_end_in  in  1 each  single-cycle event pulses
byte_data_en_in  in  1  byte valid
byte_data_in  in  8  payload byte
txfr_en_in  in  1  d_hs_rdy from transmitter
sp_en_out  out  1  short packet strobe
lp_en_out  out  1  long packet strobe
dt_out  out  6  data type
vc_out  out  2  virtual channel
wc_out  out  16  word count / frame number
byte_data_out  out  8  delayed payload
byte_data_en_out  out  1  delayed valid
txfr_en_out  out  1  txfr_en_in delayed 1 cycle
frame_number_out  out  16  current frame number
line_count_out  out  16  lines completed in current frame
config_error_out  out  1  one-cycle pulse
protocol_error_out  out  1  one-cycle pulse
length_error_out  out  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0; state IDLE; frame number 0; latched config 0 (RAW8, VC 0, width 0).
- sp_en_out <= fv_start|fv_end; lp_en_out <= lv_start (only when accepted, see states); 1-cycle latency.
- dt/wc update 1 cycle after event, hold otherwise. Priority when simultaneous: fv_start > fv_end > lv_start; lower-priority events in same cycle are dropped and protocol_error_out pulses.
- FS: dt 0x00; FE: dt 0x01; long packet dt: RAW8 0x2A, RAW10 0x2B, RAW12 0x2C, RGB565 0x22.
- Long wc, 20-bit intermediate, truncated to 16: RAW8 x; RAW10 (x*10)>>3; RAW12 (x*3)>>1; RGB565 x*2. At fv_start config_error pulses if RAW10 and x%4!=0, RAW12 and x odd, x==0, or intermediate >65535; frame still proceeds with floored/truncated wc.
- Frame number: increments at each accepted fv_start, 0/reset -> 1, FRAME_NUMBER_MAX -> 1. FS and FE wc = frame number if FRAME_NUMBER_ENABLE else 0; FE uses same value as its FS.
- vc_out updates with dt_out from latched VC.
- States: IDLE -fv_start-> FRAME; FRAME -lv_start-> LINE; LINE -lv_end-> FRAME; FRAME -fv_end-> IDLE.
- Illegal events (protocol_error pulse, 1 cycle after): lv_start/lv_end/fv_end in IDLE (ignored, no sp/lp); fv_start in FRAME/LINE (ignored); lv_start in LINE (ignored); fv_end in LINE (FE issued, line aborted without length check/line increment, -> IDLE).
- line_count_out: cleared at accepted fv_start, +1 at each lv_end in LINE, saturates at 0xFFFF.
- Byte counter: cleared at accepted lv_start, counts byte_data_en_in in LINE (saturating 16 bits); at lv_end compare to latched long wc; mismatch -> length_error pulse. byte_data_en_in with lv_end same cycle counts.
- Data path: byte_data/en delayed exactly DATA_DELAY cycles, unconditional of state; txfr_en delayed 1 cycle.

Test Plan:
- RAW10, x=1288, VC 0, 2 lines of 1610 bytes -> FS dt 0x00 wc 1; lp_en with dt 0x2B wc 1610 each line; FE dt 0x01 wc 1; line_count 2; no errors.
- Mode RGB565 x=640 VC 2 -> dt 0x22 wc 1280 vc_out 2; second frame FS wc 2; mode change mid-frame ignored until next fv_start.
- FRAME_NUMBER_MAX=3, 4 frames -> FS wc 1,2,3,1; FRAME_NUMBER_ENABLE=0 -> all FS/FE wc 0.
- RAW10 x=1290 -> config_error pulse at FS+1, wc 1612; line with 1611 bytes -> length_error at lv_end+1.
- lv_start in IDLE, fv_start in FRAME, fv_start+lv_start same cycle, fv_end in LINE -> protocol_error each, only legal packets emitted, state IDLE after fv_end.
- DATA_DELAY=5, byte pattern 0x01..0x10 -> identical on byte_data_out 5 cycles later; assert reset mid-line -> all outputs 0 immediately, next frame numbered 1.
